// File: rtl/cpu_control_fsm.sv
// ============================================================================
// cpu_control_fsm : multi-cycle RV32I control sequencer with memory handshake
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_data,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal_instr,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic        TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;

    logic [6:0] w_opcode;
    logic       w_is_r, w_is_i, w_is_load, w_is_s, w_is_b;
    logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
    logic       w_expire;
    logic       w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_unused_instr = ^instr[31:7];

    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_i     = (w_opcode == OP_I);
    assign w_is_load  = (w_opcode == OP_LOAD);
    assign w_is_s     = (w_opcode == OP_S);
    assign w_is_b     = (w_opcode == OP_B);
    assign w_is_jal   = (w_opcode == OP_JAL);
    assign w_is_jalr  = (w_opcode == OP_JALR);
    assign w_is_lui   = (w_opcode == OP_LUI);
    assign w_is_auipc = (w_opcode == OP_AUIPC);
    assign w_legal    = w_is_r | w_is_i | w_is_load | w_is_s | w_is_b |
                        w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

    // Expiry is judged on the count this wait cycle would reach
    assign w_expire = TIMEOUT_EN && ((32'(cnt_q) + 32'd1) >= MEM_TIMEOUT);

    assign alu_a_sel = w_is_auipc ? 2'd1 : (w_is_lui ? 2'd2 : 2'd0);
    assign alu_b_sel = ~(w_is_r | w_is_b);

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;

        case (state_q)
            ST_START: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (w_expire) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (w_legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                if (w_is_load || w_is_s) begin
                    state_d = ST_MEMORY;
                end else if (w_is_b) begin
                    pc_we   = 1'b1;
                    pc_src  = branch_taken ? 2'd1 : 2'd0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = w_is_s;
                if (mem_ready) begin
                    if (w_is_s) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (w_expire) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_src  = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
                wb_sel  = w_is_load ? 2'd1 : ((w_is_jal || w_is_jalr) ? 2'd2 : 2'd0);
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_START;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign state         = state_q;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
// ============================================================================
// tb_cpu_control_fsm : directed vector bench for the control sequencer
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_fsm;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_ADDI  = 32'h00108093;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;

    // {alu_a_sel, alu_b_sel}
    localparam logic [2:0] AB_R   = 3'b000;
    localparam logic [2:0] AB_I   = 3'b001;
    localparam logic [2:0] AB_LUI = 3'b101;
    localparam logic [2:0] AB_AUI = 3'b011;

    typedef struct {
        logic [31:0] instr;
        logic        taken;
        logic        ready;
        logic [2:0]  st;
        logic [12:0] outs;
        logic [1:0]  flags;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr, instr2;
    logic        branch_taken, taken2;
    logic        mem_ready, ready2;

    logic        mem_req, mem_we, mem_sel_data, ir_we, pc_we, alu_b_sel, rf_we;
    logic [1:0]  pc_src, alu_a_sel, wb_sel;
    logic [2:0]  state;
    logic        illegal_instr, bus_error;

    logic        mem_req2, mem_we2, mem_sel_data2, ir_we2, pc_we2, alu_b_sel2, rf_we2;
    logic [1:0]  pc_src2, alu_a_sel2, wb_sel2;
    logic [2:0]  state2;
    logic        illegal_instr2, bus_error2;

    int   n_tests;
    int   n_fail;
    vec_t vq[$];

    cpu_control_fsm u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel_data (mem_sel_data),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .state        (state),
        .illegal_instr(illegal_instr),
        .bus_error    (bus_error)
    );

    cpu_control_fsm #(.MEM_TIMEOUT(4)) u_dut_to (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr2),
        .branch_taken (taken2),
        .mem_ready    (ready2),
        .mem_req      (mem_req2),
        .mem_we       (mem_we2),
        .mem_sel_data (mem_sel_data2),
        .ir_we        (ir_we2),
        .pc_we        (pc_we2),
        .pc_src       (pc_src2),
        .alu_a_sel    (alu_a_sel2),
        .alu_b_sel    (alu_b_sel2),
        .rf_we        (rf_we2),
        .wb_sel       (wb_sel2),
        .state        (state2),
        .illegal_instr(illegal_instr2),
        .bus_error    (bus_error2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [12:0] mk(input logic req, input logic we, input logic sel,
                                       input logic ir, input logic pcw, input logic [1:0] psrc,
                                       input logic [2:0] ab, input logic rf, input logic [1:0] wb);
        return {req, we, sel, ir, pcw, psrc, ab, rf, wb};
    endfunction

    task automatic add(input logic [31:0] in, input logic tk, input logic rd,
                       input logic [2:0] st, input logic [12:0] o, input logic [1:0] fl);
        vec_t v;
        v.instr = in; v.taken = tk; v.ready = rd; v.st = st; v.outs = o; v.flags = fl;
        vq.push_back(v);
    endtask

    // FETCH with ready followed by DECODE for one instruction
    task automatic fd(input logic [31:0] in, input logic [2:0] ab);
        add(in, 1'b0, 1'b1, 3'd1, mk(1, 0, 0, 1, 0, 2'd0, ab, 0, 2'd0), 2'b00);
        add(in, 1'b0, 1'b1, 3'd2, mk(0, 0, 0, 0, 0, 2'd0, ab, 0, 2'd0), 2'b00);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] snap();
        return {state, mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src,
                alu_a_sel, alu_b_sel, rf_we, wb_sel, illegal_instr, bus_error};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b1; instr = I_JALR; branch_taken = 1'b0; mem_ready = 1'b0;
        instr2 = I_ADDI; taken2 = 1'b0; ready2 = 1'b0;

        // add: START, FETCH, DECODE, EXECUTE, WRITEBACK
        add(I_ADD, 0, 1, 3'd0, mk(0, 0, 0, 0, 0, 2'd0, AB_R, 0, 2'd0), 2'b00);
        fd(I_ADD, AB_R);
        add(I_ADD, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_R, 0, 2'd0), 2'b00);
        add(I_ADD, 0, 1, 3'd5, mk(0, 0, 0, 0, 1, 2'd0, AB_R, 1, 2'd0), 2'b00);
        // lw with three wait cycles in MEMORY
        fd(I_LW, AB_I);
        add(I_LW, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        for (int k = 0; k < 3; k++)
            add(I_LW, 0, 0, 3'd4, mk(1, 0, 1, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        add(I_LW, 0, 1, 3'd4, mk(1, 0, 1, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        add(I_LW, 0, 1, 3'd5, mk(0, 0, 0, 0, 1, 2'd0, AB_I, 1, 2'd1), 2'b00);
        // sw completes from MEMORY straight to FETCH
        fd(I_SW, AB_I);
        add(I_SW, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        add(I_SW, 0, 1, 3'd4, mk(1, 1, 1, 0, 1, 2'd0, AB_I, 0, 2'd0), 2'b00);
        // beq taken then not taken
        fd(I_BEQ, AB_R);
        add(I_BEQ, 1, 1, 3'd3, mk(0, 0, 0, 0, 1, 2'd1, AB_R, 0, 2'd0), 2'b00);
        fd(I_BEQ, AB_R);
        add(I_BEQ, 0, 1, 3'd3, mk(0, 0, 0, 0, 1, 2'd0, AB_R, 0, 2'd0), 2'b00);
        // jalr, jal, lui, auipc writebacks
        fd(I_JALR, AB_I);
        add(I_JALR, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        add(I_JALR, 0, 1, 3'd5, mk(0, 0, 0, 0, 1, 2'd2, AB_I, 1, 2'd2), 2'b00);
        fd(I_JAL, AB_I);
        add(I_JAL, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        add(I_JAL, 0, 1, 3'd5, mk(0, 0, 0, 0, 1, 2'd1, AB_I, 1, 2'd2), 2'b00);
        fd(I_LUI, AB_LUI);
        add(I_LUI, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_LUI, 0, 2'd0), 2'b00);
        add(I_LUI, 0, 1, 3'd5, mk(0, 0, 0, 0, 1, 2'd0, AB_LUI, 1, 2'd0), 2'b00);
        fd(I_AUIPC, AB_AUI);
        add(I_AUIPC, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_AUI, 0, 2'd0), 2'b00);
        add(I_AUIPC, 0, 1, 3'd5, mk(0, 0, 0, 0, 1, 2'd0, AB_AUI, 1, 2'd0), 2'b00);
        // addi with two fetch wait cycles
        add(I_ADDI, 0, 0, 3'd1, mk(1, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        add(I_ADDI, 0, 0, 3'd1, mk(1, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        fd(I_ADDI, AB_I);
        add(I_ADDI, 0, 1, 3'd3, mk(0, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00);
        add(I_ADDI, 0, 1, 3'd5, mk(0, 0, 0, 0, 1, 2'd0, AB_I, 1, 2'd0), 2'b00);
        // illegal opcode parks in TRAP with sticky flag
        fd(I_ILL, AB_I);
        for (int k = 0; k < 20; k++)
            add(I_ILL, 0, 1, 3'd6, mk(0, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b10);

        // reset state
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", 32'(snap()),
            32'({3'd0, mk(0, 0, 0, 0, 0, 2'd0, AB_I, 0, 2'd0), 2'b00}));
        chk("reset_state2", 32'(state2), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            instr        = vq[i].instr;
            branch_taken = vq[i].taken;
            mem_ready    = vq[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(snap()),
                32'({vq[i].st, vq[i].outs, vq[i].flags}));
            @(posedge clk); #1;
        end

        // fetch timeout with MEM_TIMEOUT=4
        rst_n = 1'b0; mem_ready = 1'b0; ready2 = 1'b0; instr2 = I_ADDI;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("to_start", 32'(state2), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("to_wait%0d", k), 32'({state2, mem_req2, bus_error2}),
                32'({3'd1, 1'b1, 1'b0}));
        end
        @(posedge clk); #1;
        chk("to_trap", 32'({state2, mem_req2, bus_error2}), 32'({3'd6, 1'b0, 1'b1}));
        @(posedge clk); #1;
        chk("to_sticky", 32'({state2, bus_error2}), 32'({3'd6, 1'b1}));

        // ready on the expiry cycle wins; reset mid-MEMORY on the main unit
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; instr = I_LW; mem_ready = 1'b1; ready2 = 1'b0;
        @(posedge clk); #1;
        chk("rw_fetch", 32'({state, state2}), 32'({3'd1, 3'd1}));
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        ready2 = 1'b1;
        #1 chk("rw_expiry_ready", 32'({state2, ir_we2}), 32'({3'd1, 1'b1}));
        chk("rst_mem_pre", 32'({state, mem_req, mem_sel_data}), 32'({3'd4, 1'b1, 1'b1}));
        @(posedge clk); #1;
        chk("rw_decode", 32'({state2, bus_error2}), 32'({3'd2, 1'b0}));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 32'({state, mem_req, mem_sel_data, pc_we, rf_we, state2}),
               32'({3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}));
        @(posedge clk); #1;
        chk("rst_hold", 32'({state, mem_req, ir_we}), 32'({3'd0, 1'b0, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
